// File: rtl/beat_timing_gen.sv
// rtl/beat_timing_gen.sv - machine-cycle beat generator (W1/W2/W3) with start sync, stop latch and cycle counter
module beat_timing_gen #(
    parameter int CNT_W   = 8,
    parameter bit SYNC_EN = 1'b1
) (
    input  logic             t3,
    input  logic             clr,
    input  logic             qd,
    input  logic             step_mode,
    input  logic             short,
    input  logic             long,
    input  logic             stop,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             running,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_W1   = 2'd1,
        S_W2   = 2'd2,
        S_W3   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_qd_prev;
    logic             r_stop_hit;
    logic [CNT_W-1:0] r_cnt;
    logic             w_qd_s;
    logic             w_go;
    logic             w_end;

    generate
        if (SYNC_EN) begin : g_sync
            logic r_sync1;
            logic r_sync2;
            always_ff @(posedge t3 or posedge clr) begin
                if (clr) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= qd;
                    r_sync2 <= r_sync1;
                end
            end
            assign w_qd_s = r_sync2;
        end else begin : g_nosync
            assign w_qd_s = qd;
        end
    endgenerate

    assign w_go = w_qd_s & ~r_qd_prev;

    // w_end marks the final edge of a machine cycle; halt decision is taken only there
    always_comb begin
        w_next = r_state;
        w_end  = 1'b0;
        case (r_state)
            S_IDLE: if (w_go) w_next = S_W1;
            S_W1: begin
                if (short) w_end = 1'b1;
                else       w_next = S_W2;
            end
            S_W2: begin
                if (long) w_next = S_W3;
                else      w_end = 1'b1;
            end
            S_W3:    w_end = 1'b1;
            default: w_next = S_IDLE;
        endcase
        if (w_end) begin
            w_next = (r_stop_hit | stop | step_mode) ? S_IDLE : S_W1;
        end
    end

    always_ff @(posedge t3 or posedge clr) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_qd_prev  <= 1'b0;
            r_stop_hit <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state   <= w_next;
            r_qd_prev <= w_qd_s;
            if (w_end) begin
                r_stop_hit <= 1'b0;
                r_cnt      <= r_cnt + 1'b1;
            end else if (r_state != S_IDLE) begin
                r_stop_hit <= r_stop_hit | stop;
            end
        end
    end

    assign w1        = (r_state == S_W1);
    assign w2        = (r_state == S_W2);
    assign w3        = (r_state == S_W3);
    assign running   = (r_state != S_IDLE);
    assign cycle_cnt = r_cnt;

endmodule

// File: tb/tb_beat_timing_gen.sv
// tb/tb_beat_timing_gen.sv - scoreboard bench for beat_timing_gen (default and CNT_W=2/SYNC_EN=0 instances)
module tb_beat_timing_gen;

    localparam logic [2:0] B0 = 3'b000;
    localparam logic [2:0] B1 = 3'b001;
    localparam logic [2:0] B2 = 3'b010;
    localparam logic [2:0] B3 = 3'b100;

    logic       t3, clr, qd, step_mode, short, long, stop;
    logic       a_w1, a_w2, a_w3, a_run;
    logic [7:0] a_cnt;
    logic       b_w1, b_w2, b_w3, b_run;
    logic [1:0] b_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] beats;
        int         cnt;
        bit         sel;
    } exp_t;
    exp_t sb[$];

    beat_timing_gen #(.CNT_W(8), .SYNC_EN(1'b1)) u_dut_a (
        .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode), .short(short), .long(long), .stop(stop),
        .w1(a_w1), .w2(a_w2), .w3(a_w3), .running(a_run), .cycle_cnt(a_cnt)
    );

    beat_timing_gen #(.CNT_W(2), .SYNC_EN(1'b0)) u_dut_b (
        .t3(t3), .clr(clr), .qd(qd), .step_mode(step_mode), .short(short), .long(long), .stop(stop),
        .w1(b_w1), .w2(b_w2), .w3(b_w3), .running(b_run), .cycle_cnt(b_cnt)
    );

    initial t3 = 1'b0;
    always #5 t3 = ~t3;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic compare_dut(input string tag, input bit sel, input logic [2:0] beats, input int cnt);
        if (!sel) begin
            check({tag, "/a_beats"}, int'({a_w3, a_w2, a_w1}), int'(beats));
            check({tag, "/a_run"}, int'(a_run), int'(beats != B0));
            check({tag, "/a_cnt"}, int'(a_cnt), cnt);
        end else begin
            check({tag, "/b_beats"}, int'({b_w3, b_w2, b_w1}), int'(beats));
            check({tag, "/b_run"}, int'(b_run), int'(beats != B0));
            check({tag, "/b_cnt"}, int'(b_cnt), cnt);
        end
    endtask

    // expectation is queued before the edge and retired after the DUT reacts to it
    task automatic cyc(input string tag, input logic [2:0] beats, input int cnt, input bit sel);
        exp_t e;
        e.beats = beats;
        e.cnt   = cnt;
        e.sel   = sel;
        sb.push_back(e);
        @(posedge t3);
        #1;
        e = sb.pop_front();
        compare_dut(tag, e.sel, e.beats, e.cnt);
    endtask

    task automatic do_reset(input string tag);
        @(negedge t3);
        clr       = 1'b1;
        qd        = 1'b0;
        step_mode = 1'b0;
        short     = 1'b0;
        long      = 1'b0;
        stop      = 1'b0;
        #1;
        compare_dut({tag, "/rst"}, 1'b0, B0, 0);
        compare_dut({tag, "/rst"}, 1'b1, B0, 0);
        @(posedge t3);
        #1;
        clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; qd = 1'b0; step_mode = 1'b0; short = 1'b0; long = 1'b0; stop = 1'b0;

        // run mode, 2-beat cycles; stop while idle must not matter
        do_reset("A");
        stop = 1'b1;
        qd   = 1'b1;
        cyc("A_e1", B0, 0, 0);
        cyc("A_e2", B0, 0, 0);
        stop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc("A_w1", B1, k, 0);
            cyc("A_w2", B2, k, 0);
        end

        // long cycles W1,W2,W3
        do_reset("B");
        long = 1'b1;
        qd   = 1'b1;
        cyc("B_e1", B0, 0, 0);
        cyc("B_e2", B0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc("B_w1", B1, k, 0);
            cyc("B_w2", B2, k, 0);
            cyc("B_w3", B3, k, 0);
        end
        cyc("B_after9", B1, 3, 0);

        // short cycles, with long also high: short wins
        do_reset("C");
        short = 1'b1;
        long  = 1'b1;
        qd    = 1'b1;
        cyc("C_e1", B0, 0, 0);
        cyc("C_e2", B0, 0, 0);
        for (int k = 0; k < 6; k++) cyc("C_w1", B1, k, 0);

        // single step
        do_reset("D");
        step_mode = 1'b1;
        qd        = 1'b1;
        cyc("D_e1", B0, 0, 0);
        cyc("D_e2", B0, 0, 0);
        cyc("D_w1", B1, 0, 0);
        cyc("D_w2", B2, 0, 0);
        cyc("D_halt", B0, 1, 0);
        cyc("D_hold", B0, 1, 0);
        qd = 1'b0;
        for (int k = 0; k < 3; k++) cyc("D_rel", B0, 1, 0);
        qd = 1'b1;
        cyc("D_e1b", B0, 1, 0);
        cyc("D_e2b", B0, 1, 0);
        cyc("D_w1b", B1, 1, 0);
        cyc("D_w2b", B2, 1, 0);
        cyc("D_halt2", B0, 2, 0);

        // stop pulse in W1 of a long cycle; go arriving on the END edge is discarded
        do_reset("E");
        long = 1'b1;
        qd   = 1'b1;
        cyc("E_e1", B0, 0, 0);
        cyc("E_e2", B0, 0, 0);
        qd = 1'b0;
        cyc("E_w1", B1, 0, 0);
        qd   = 1'b1;
        stop = 1'b1;
        cyc("E_w2", B2, 0, 0);
        stop = 1'b0;
        cyc("E_w3", B3, 0, 0);
        cyc("E_end", B0, 1, 0);
        cyc("E_idle1", B0, 1, 0);
        cyc("E_idle2", B0, 1, 0);

        // narrow counter, unsynchronised start, clr during W2
        do_reset("F");
        qd = 1'b1;
        cyc("F_w1_first", B1, 0, 1);
        cyc("F_w2", B2, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc("F_w1", B1, k % 4, 1);
            cyc("F_w2", B2, k % 4, 1);
        end
        cyc("F_w1_last", B1, 1, 1);
        cyc("F_w2_last", B2, 1, 1);
        do_reset("F_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
